// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: R = (a * b) mod p, one bit of b per clock, MSB first.
// Optional operand range check enabled by defining MODMUL_RANGE_CHECK_EN.
module mod_mul_serial #(
   parameter int Data_Width = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [Data_Width-1:0] a,
   input  logic [Data_Width-1:0] b,
   input  logic [Data_Width-1:0] p,
   input  logic                  valid_in,
   output logic [Data_Width-1:0] R,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  err
);

   localparam int CNT_W = (Data_Width > 2) ? $clog2(Data_Width) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
`ifdef MODMUL_RANGE_CHECK_EN
   localparam logic [1:0] S_RERR = 2'd3;
`endif

   logic [1:0]            state;
   logic [Data_Width-1:0] a_reg;
   logic [Data_Width-1:0] b_reg;
   logic [Data_Width-1:0] p_reg;
   logic [Data_Width-1:0] acc;
   logic [CNT_W-1:0]      cnt;

   logic [Data_Width:0]   p_ext;
   logic [Data_Width:0]   dbl;
   logic [Data_Width:0]   t1;
   logic [Data_Width:0]   sum;
   logic [Data_Width-1:0] t2;

   // One interleaved step: double-and-reduce, then conditional add-and-reduce.
   always_comb begin
      p_ext = {1'b0, p_reg};
      dbl   = {acc, 1'b0};
      t1    = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
      sum   = t1 + (b_reg[cnt] ? {1'b0, a_reg} : '0);
      t2    = (sum >= p_ext) ? Data_Width'(sum - p_ext) : Data_Width'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         p_reg     <= '0;
         acc       <= '0;
         cnt       <= '0;
         R         <= '0;
         valid_out <= 1'b0;
         busy      <= 1'b0;
`ifdef MODMUL_RANGE_CHECK_EN
         err       <= 1'b0;
`endif
      end else begin
         valid_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (valid_in) begin
                  a_reg <= a;
                  b_reg <= b;
                  p_reg <= p;
                  acc   <= '0;
                  cnt   <= CNT_W'(Data_Width - 1);
                  busy  <= 1'b1;
`ifdef MODMUL_RANGE_CHECK_EN
                  if ((a >= p) || (b >= p) || (p < Data_Width'(2)))
                     state <= S_RERR;
                  else
                     state <= S_CALC;
`else
                  state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               acc <= t2;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  R         <= t2;
                  valid_out <= 1'b1;
                  state     <= S_DONE;
`ifdef MODMUL_RANGE_CHECK_EN
                  err       <= 1'b0;
`endif
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
`ifdef MODMUL_RANGE_CHECK_EN
            S_RERR: begin
               R         <= '0;
               err       <= 1'b1;
               valid_out <= 1'b1;
               state     <= S_DONE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef MODMUL_RANGE_CHECK_EN
   assign err = 1'b0;
`endif

endmodule
